// File: rtl/chord_pkg.sv
// ----------------------------------------------------------------------------
// chord_pkg
//   Shared definitions for the CHORD CORDIC input stage:
//     - state_e       : input-stage FSM states
//     - *_BIT         : bit positions of the control flags in the 32-bit
//                       command word (payload sits in the low bits)
//     - angle_const() : 90/180/360 degree constants scaled to the angle's
//                       fixed-point format
// ----------------------------------------------------------------------------
package chord_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_X = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int CMD_WIDTH     = 32;
  localparam int ARCTAN_EN_BIT = 16;
  localparam int TWO_BEAT_BIT  = 17;

  // Degree constant in the angle payload's fixed-point format.
  function automatic logic signed [31:0] angle_const(input int deg, input int frac);
    return 32'(deg <<< frac);
  endfunction

endpackage

// File: rtl/angle_fold_unit.sv
// ----------------------------------------------------------------------------
// angle_fold_unit
//   Combinational single step of the angle reduction loop.
//   If acc lies outside [-180,180] one 360 step is applied and done = 0.
//   Otherwise done = 1 and the angle is folded into [-90,90]; flip tells the
//   core to negate both sin and cos results.
// Ports
//   acc      in   ACC_WIDTH   current signed angle accumulator
//   acc_next out  ACC_WIDTH   accumulator after one reduce step
//   done     out  1           acc already in [-180,180]; degree/flip valid
//   degree   out  OUT_WIDTH   folded angle (sign-extended or truncated)
//   flip     out  FLIP_WIDTH  1 when the fold moved the angle by 180
// ----------------------------------------------------------------------------
module angle_fold_unit
  import chord_pkg::*;
#(
  parameter int ACC_WIDTH        = 18,
  parameter int OUT_WIDTH        = 16,
  parameter int FLIP_WIDTH       = 1,
  parameter int ANGLE_FRAC_WIDTH = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  acc_next,
  output logic                         done,
  output logic signed [OUT_WIDTH-1:0]  degree,
  output logic        [FLIP_WIDTH-1:0] flip
);

  localparam logic signed [ACC_WIDTH-1:0] C90  = ACC_WIDTH'(angle_const(90,  ANGLE_FRAC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] C180 = ACC_WIDTH'(angle_const(180, ANGLE_FRAC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] C360 = ACC_WIDTH'(angle_const(360, ANGLE_FRAC_WIDTH));

  logic signed [ACC_WIDTH-1:0] folded;

  always_comb begin
    acc_next = acc;
    done     = 1'b0;
    folded   = acc;
    flip     = '0;
    if (acc > C180) begin
      acc_next = acc - C360;
    end else if (acc < -C180) begin
      acc_next = acc + C360;
    end else begin
      done = 1'b1;
      // Exactly +/-90 stays unfolded; exactly +/-180 folds to 0 with flip.
      if (acc > C90) begin
        folded = acc - C180;
        flip   = FLIP_WIDTH'(1);
      end else if (acc < -C90) begin
        folded = acc + C180;
        flip   = FLIP_WIDTH'(1);
      end
    end
  end

  // Signed size cast: sign-extends when widening, truncates when narrowing.
  assign degree = OUT_WIDTH'(folded);

endmodule

// File: rtl/cordic_input_stage.sv
// ----------------------------------------------------------------------------
// cordic_input_stage
//   Registered, handshaked front end of the CHORD CORDIC core. Unpacks a
//   32-bit command word and presents one operand set per command:
//     rotate        : angle reduced to [-180,180], folded to [-90,90] + flip
//     arctan        : y = payload, x = 1.0
//     atan2 (2 beat): first word y, second word x
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_interface        [15:0] payload, [16] arctan_en, [17] two_beat
//   valid_in_interface  command word valid
//   ready_in_interface  stage can accept a word (IDLE / WAIT_X)
//   ready_out           CORDIC core accepts the current outputs
//   degree_in           folded angle, signed
//   x_in, y_in          operands in OUTPUT_FRAC_WIDTH fixed point
//   flip_in             core must negate both sin and cos results
//   arctan_en_in        vectoring mode
//   valid_in            outputs valid (held until ready_out)
// ----------------------------------------------------------------------------
module cordic_input_stage
  import chord_pkg::*;
#(
  parameter int INPUT_WIDTH       = 16,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int INPUT_FRAC_WIDTH  = 8,
  parameter int OUTPUT_FRAC_WIDTH = 8,
  parameter int ANGLE_FRAC_WIDTH  = 0,
  parameter int FLIP_FLAG_WIDTH   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic        [CMD_WIDTH-1:0]       in_interface,
  input  logic                              valid_in_interface,
  output logic                              ready_in_interface,
  input  logic                              ready_out,
  output logic signed [OUTPUT_WIDTH-1:0]    degree_in,
  output logic signed [OUTPUT_WIDTH-1:0]    x_in,
  output logic signed [OUTPUT_WIDTH-1:0]    y_in,
  output logic        [FLIP_FLAG_WIDTH-1:0] flip_in,
  output logic                              arctan_en_in,
  output logic                              valid_in
);

  // Two guard bits so a single +/-360 step can never overflow.
  localparam int ACC_WIDTH  = INPUT_WIDTH + 2;
  localparam int FRAC_SHIFT = OUTPUT_FRAC_WIDTH - INPUT_FRAC_WIDTH;
  localparam int WIDE_WIDTH = (FRAC_SHIFT > 0) ? INPUT_WIDTH + FRAC_SHIFT : INPUT_WIDTH;
  localparam logic signed [OUTPUT_WIDTH-1:0] ONE_FIXED =
      OUTPUT_WIDTH'(angle_const(1, OUTPUT_FRAC_WIDTH));

  // --------------------------------------------------------------------------
  // Command word decode and operand scaling
  // --------------------------------------------------------------------------
  logic signed [INPUT_WIDTH-1:0]  payload;
  logic signed [WIDE_WIDTH-1:0]   payload_wide;
  logic signed [WIDE_WIDTH-1:0]   payload_scaled;
  logic signed [OUTPUT_WIDTH-1:0] operand;
  logic                           cmd_arctan;
  logic                           cmd_two_beat;
  logic                           unused_cmd_bits;

  assign payload      = in_interface[INPUT_WIDTH-1:0];
  assign cmd_arctan   = in_interface[ARCTAN_EN_BIT];
  assign cmd_two_beat = in_interface[TWO_BEAT_BIT];
  assign payload_wide = WIDE_WIDTH'(payload);

  // Left shift zero-fills; right shift is arithmetic (truncates toward -inf).
  generate
    if (FRAC_SHIFT >= 0) begin : g_shift_left
      assign payload_scaled = payload_wide <<< FRAC_SHIFT;
    end else begin : g_shift_right
      assign payload_scaled = payload_wide >>> (-FRAC_SHIFT);
    end
  endgenerate

  assign operand         = OUTPUT_WIDTH'(payload_scaled);
  assign unused_cmd_bits = ^in_interface[CMD_WIDTH-1:TWO_BEAT_BIT+1];

  // --------------------------------------------------------------------------
  // Reduce / fold step
  // --------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]       fold_acc_next;
  logic                              fold_done;
  logic signed [OUTPUT_WIDTH-1:0]    fold_degree;
  logic        [FLIP_FLAG_WIDTH-1:0] fold_flip;

  angle_fold_unit #(
    .ACC_WIDTH        (ACC_WIDTH),
    .OUT_WIDTH        (OUTPUT_WIDTH),
    .FLIP_WIDTH       (FLIP_FLAG_WIDTH),
    .ANGLE_FRAC_WIDTH (ANGLE_FRAC_WIDTH)
  ) u_fold (
    .acc      (acc_q),
    .acc_next (fold_acc_next),
    .done     (fold_done),
    .degree   (fold_degree),
    .flip     (fold_flip)
  );

  // --------------------------------------------------------------------------
  // FSM and output registers
  // --------------------------------------------------------------------------
  state_e                            state_q, state_d;
  logic signed [OUTPUT_WIDTH-1:0]    degree_q, degree_d;
  logic signed [OUTPUT_WIDTH-1:0]    x_q, x_d;
  logic signed [OUTPUT_WIDTH-1:0]    y_q, y_d;
  logic        [FLIP_FLAG_WIDTH-1:0] flip_q, flip_d;
  logic                              arctan_q, arctan_d;
  logic                              valid_q, valid_d;
  logic                              ready_q, ready_d;
  logic                              accept;

  assign accept = valid_in_interface && ready_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    degree_d = degree_q;
    x_d      = x_q;
    y_d      = y_q;
    flip_d   = flip_q;
    arctan_d = arctan_q;
    valid_d  = valid_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_arctan) begin
            y_d      = operand;
            degree_d = '0;
            flip_d   = '0;
            arctan_d = 1'b1;
            if (cmd_two_beat) begin
              state_d = WAIT_X;
              ready_d = 1'b1;
            end else begin
              x_d     = ONE_FIXED;
              state_d = HOLD;
              valid_d = 1'b1;
              ready_d = 1'b0;
            end
          end else begin
            // two_beat without arctan_en is an ordinary rotate.
            acc_d    = ACC_WIDTH'(payload);
            x_d      = ONE_FIXED;
            y_d      = '0;
            arctan_d = 1'b0;
            state_d  = REDUCE;
            ready_d  = 1'b0;
          end
        end
      end

      WAIT_X: begin
        if (accept) begin
          x_d     = operand;
          state_d = HOLD;
          valid_d = 1'b1;
          ready_d = 1'b0;
        end
      end

      REDUCE: begin
        acc_d = fold_acc_next;
        if (fold_done) begin
          degree_d = fold_degree;
          flip_d   = fold_flip;
          state_d  = HOLD;
          valid_d  = 1'b1;
        end
      end

      HOLD: begin
        if (ready_out) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      degree_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      flip_q   <= '0;
      arctan_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      degree_q <= degree_d;
      x_q      <= x_d;
      y_q      <= y_d;
      flip_q   <= flip_d;
      arctan_q <= arctan_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_in_interface = ready_q;
  assign degree_in          = degree_q;
  assign x_in               = x_q;
  assign y_in               = y_q;
  assign flip_in            = flip_q;
  assign arctan_en_in       = arctan_q;
  assign valid_in           = valid_q;

endmodule

// File: tb/tb_cordic_input_stage.sv
// ----------------------------------------------------------------------------
// tb_cordic_input_stage
//   Directed cases followed by randomized rotate / arctan / atan2 commands,
//   each checked against a reference model that reduces angles with modular
//   arithmetic and derives latency from the closed-form step count.
// ----------------------------------------------------------------------------
module tb_cordic_input_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        in_interface;
  logic               valid_in_interface;
  logic               ready_in_interface;
  logic               ready_out;
  logic signed [15:0] degree_in;
  logic [15:0]        x_in;
  logic [15:0]        y_in;
  logic [0:0]         flip_in;
  logic               arctan_en_in;
  logic               valid_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_input_stage #(
    .INPUT_WIDTH       (16),
    .OUTPUT_WIDTH      (16),
    .INPUT_FRAC_WIDTH  (8),
    .OUTPUT_FRAC_WIDTH (8),
    .ANGLE_FRAC_WIDTH  (0),
    .FLIP_FLAG_WIDTH   (1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_interface       (in_interface),
    .valid_in_interface (valid_in_interface),
    .ready_in_interface (ready_in_interface),
    .ready_out          (ready_out),
    .degree_in          (degree_in),
    .x_in               (x_in),
    .y_in               (y_in),
    .flip_in            (flip_in),
    .arctan_en_in       (arctan_en_in),
    .valid_in           (valid_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: wrap into [-180,180) by modulo, then fold into [-90,90].
  function automatic void ref_rotate(input int a, output int deg, output int flip, output int lat);
    int r;
    int mag;
    r = (((a + 180) % 360) + 360) % 360 - 180;
    if (r > 90) begin
      deg = r - 180; flip = 1;
    end else if (r < -90) begin
      deg = r + 180; flip = 1;
    end else begin
      deg = r; flip = 0;
    end
    mag = (a < 0) ? -a : a;
    lat = (mag > 180) ? 2 + (mag - 180 + 359) / 360 : 2;
  endfunction

  task automatic send_word(input logic [31:0] w);
    int waited = 0;
    while (!ready_in_interface && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_wait", 32'(ready_in_interface), 32'd1);
    in_interface       = w;
    valid_in_interface = 1'b1;
    @(posedge clk); #1;
    valid_in_interface = 1'b0;
    in_interface       = $urandom;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (!valid_in && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(valid_in), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_outputs(input string tag, input int exp_deg, input int exp_flip,
                               input logic [15:0] exp_x, input logic [15:0] exp_y,
                               input logic exp_at);
    check({tag, "_deg"},   32'(degree_in),    32'(exp_deg));
    check({tag, "_flip"},  32'(flip_in),      32'(exp_flip));
    check({tag, "_x"},     32'(x_in),         32'(exp_x));
    check({tag, "_y"},     32'(y_in),         32'(exp_y));
    check({tag, "_mode"},  32'(arctan_en_in), 32'(exp_at));
    check({tag, "_rdy"},   32'(ready_in_interface), 32'd0);
  endtask

  // Optional stall with ready_out low, then handshake and check return to IDLE.
  task automatic hold_and_release(input string tag, input int stall, input int exp_deg,
                                  input int exp_flip, input logic [15:0] exp_x,
                                  input logic [15:0] exp_y, input logic exp_at);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(valid_in), 32'd1);
      check_outputs({tag, "_stall"}, exp_deg, exp_flip, exp_x, exp_y, exp_at);
    end
    ready_out = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_valid"}, 32'(valid_in), 32'd0);
    check({tag, "_done_rdy"},   32'(ready_in_interface), 32'd1);
  endtask

  task automatic do_rotate(input int a, input int stall);
    int deg, flip, lat;
    logic [31:0] r;
    logic [15:0] a16;
    ref_rotate(a, deg, flip, lat);
    r   = $urandom;
    a16 = 16'(a);
    ready_out = (stall == 0);
    // bit 17 randomly set: two_beat without arctan_en is still a rotate
    send_word({14'b0, r[0], 1'b0, a16});
    wait_valid("rot", lat);
    check_outputs("rot", deg, flip, 16'h0100, 16'h0000, 1'b0);
    $display("rotate a=%0d -> degree=%0d flip=%0d latency=%0d stall=%0d", a, deg, flip, lat, stall);
    hold_and_release("rot", stall, deg, flip, 16'h0100, 16'h0000, 1'b0);
  endtask

  task automatic do_arctan(input logic [15:0] yv, input int stall);
    ready_out = (stall == 0);
    send_word({14'b0, 2'b01, yv});
    wait_valid("atan", 1);
    check_outputs("atan", 0, 0, 16'h0100, yv, 1'b1);
    $display("arctan y=0x%04h x=0x0100 stall=%0d", yv, stall);
    hold_and_release("atan", stall, 0, 0, 16'h0100, yv, 1'b1);
  endtask

  task automatic do_atan2(input logic [15:0] yv, input logic [15:0] xv, input int gap,
                          input int stall);
    logic [31:0] r;
    r = $urandom;
    ready_out = (stall == 0);
    send_word({14'b0, 2'b11, yv});
    check("atan2_wait_rdy",   32'(ready_in_interface), 32'd1);
    check("atan2_wait_valid", 32'(valid_in), 32'd0);
    repeat (gap) @(posedge clk);
    #1;
    send_word({r[15:0], xv});
    wait_valid("atan2", 1);
    check_outputs("atan2", 0, 0, xv, yv, 1'b1);
    $display("atan2 y=0x%04h x=0x%04h gap=%0d stall=%0d", yv, xv, gap, stall);
    hold_and_release("atan2", stall, 0, 0, xv, yv, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_deg"},   32'(degree_in),    32'd0);
    check({tag, "_x"},     32'(x_in),         32'd0);
    check({tag, "_y"},     32'(y_in),         32'd0);
    check({tag, "_flip"},  32'(flip_in),      32'd0);
    check({tag, "_mode"},  32'(arctan_en_in), 32'd0);
    check({tag, "_valid"}, 32'(valid_in),     32'd0);
    check({tag, "_rdy"},   32'(ready_in_interface), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int angles[10] = '{30, 150, -120, 90, -90, 180, -180, 1000, 540, -1000};
    rst                = 1'b1;
    in_interface       = '0;
    valid_in_interface = 1'b0;
    ready_out          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (angles[i]) do_rotate(angles[i], 0);
    do_arctan(16'h0180, 0);
    do_atan2(16'h0100, 16'h0200, 0, 0);
    do_rotate(45, 5);

    // Asynchronous reset while in REDUCE discards the word.
    ready_out = 1'b1;
    send_word(32'h0000_03E8);
    check("rst_pre_x", 32'(x_in), 32'h0000_0100);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("post_rst");
    $display("async reset during REDUCE");

    for (int n = 0; n < 60; n++) begin
      int mode;
      int stall;
      int a;
      logic [31:0] r1;
      logic [31:0] r2;
      mode  = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      r1    = $urandom;
      r2    = $urandom;
      case (mode)
        0: begin
          if (r1[31]) a = int'($signed(r1[15:0]));
          else        a = int'($urandom_range(0, 1440)) - 720;
          do_rotate(a, stall);
        end
        1: do_arctan(r1[15:0], stall);
        default: do_atan2(r1[15:0], r2[15:0], $urandom_range(0, 3), stall);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
